// File: rtl/axi_c2c_resp_pkg.sv
// Shared constants, FSM state types and burst address stepping for the
// AXI chip-to-chip memory responder.
package axi_c2c_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Widest address the stepping helper handles; callers cast to their width.
  localparam int MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Beats are always 4 bytes; reserved burst encodings step like INCR.
  function automatic logic [MAX_ADDR_W-1:0] next_addr(input logic [MAX_ADDR_W-1:0] addr,
                                                      input logic [1:0]            burst);
    return (burst == BURST_FIXED) ? addr : addr + 64'd4;
  endfunction

endpackage

// File: rtl/axi_c2c_resp_mem.sv
// Word-wide register array: one byte-strobed write port, one registered read
// port. A read and write to the same index on one edge returns the old word.
module axi_c2c_resp_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_strb,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? 32'h0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_c2c_mem_responder.sv
// AXI4 slave memory responder for the far end of the chip-to-chip link.
// Optional out-of-range checking is enabled by AXI_C2C_RESP_RANGE_CHECK_EN.
//
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting beats until counter == len
//   W_RESP | bvalid high until bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, next word prefetched on each accepted beat
module axi_c2c_mem_responder
  import axi_c2c_resp_pkg::*;
#(
  parameter int                ID_W        = 6,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [3:0]        s_axi_wuser,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              w_beat, w_last_beat, w_oor, mem_wr_en;
  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;

  r_state_t          r_state, r_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_burst;
  logic              r_oor_q;
  logic              ar_hs, r_adv, r_last_beat, rd_oor;
  logic [ADDR_W-1:0] rd_addr, rd_off;
  logic [IDX_W-1:0]  rd_idx;

  // Index = offset from base in words, silently wrapping modulo depth.
  assign w_off  = w_addr - BASE_ADDR;
  assign w_idx  = w_off[IDX_W+1:2];
  assign rd_addr = (r_state == R_IDLE) ? s_axi_araddr : r_addr;
  assign rd_off = rd_addr - BASE_ADDR;
  assign rd_idx = rd_off[IDX_W+1:2];

`ifdef AXI_C2C_RESP_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] ADDR_END = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH_WORDS);

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a < BASE_ADDR) || ({1'b0, a} >= ADDR_END);
  endfunction

  assign w_oor  = out_of_range(w_addr);
  assign rd_oor = out_of_range(rd_addr);
`else
  assign w_oor  = 1'b0;
  assign rd_oor = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_arsize, s_axi_wuser, w_off, rd_off};

  // ---------------------------------------------------------------- write
  assign w_last_beat = (w_cnt == w_len);
  assign s_axi_bid   = w_id;

  always_comb begin
    w_state_nxt   = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    w_beat        = 1'b0;
    mem_wr_en     = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          w_beat    = 1'b1;
          mem_wr_en = !w_oor;
          if (w_last_beat) w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = w_err ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_INCR;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && s_axi_awvalid) begin
        w_id    <= s_axi_awid;
        w_addr  <= s_axi_awaddr;
        w_len   <= s_axi_awlen;
        w_burst <= s_axi_awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_beat) begin
        w_addr <= ADDR_W'(next_addr(MAX_ADDR_W'(w_addr), w_burst));
        w_cnt  <= w_cnt + 8'd1;
        // Termination is by count; a misplaced or missing wlast only flags the burst.
        if ((s_axi_wlast != w_last_beat) || w_oor) w_err <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------------------- read
  assign r_last_beat = (r_cnt == r_len);
  assign s_axi_rid   = r_id;

  always_comb begin
    r_state_nxt   = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = RESP_OKAY;
    ar_hs         = 1'b0;
    r_adv         = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ar_hs       = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = r_last_beat;
        s_axi_rresp  = r_oor_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_rready) begin
          if (r_last_beat) r_state_nxt = R_IDLE;
          else             r_adv       = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // r_addr always holds the address of the beat that will be fetched next.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_INCR;
      r_oor_q <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        r_id    <= s_axi_arid;
        r_len   <= s_axi_arlen;
        r_burst <= s_axi_arburst;
        r_addr  <= ADDR_W'(next_addr(MAX_ADDR_W'(s_axi_araddr), s_axi_arburst));
        r_cnt   <= '0;
        r_oor_q <= rd_oor;
      end
      if (r_adv) begin
        r_addr  <= ADDR_W'(next_addr(MAX_ADDR_W'(r_addr), r_burst));
        r_cnt   <= r_cnt + 8'd1;
        r_oor_q <= rd_oor;
      end
    end
  end

  axi_c2c_resp_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk    (s_aclk),
    .rst_n  (s_aresetn),
    .wr_en  (mem_wr_en),
    .wr_idx (w_idx),
    .wr_strb(s_axi_wstrb),
    .wr_data(s_axi_wdata),
    .rd_en  (ar_hs | r_adv),
    .rd_zero(rd_oor),
    .rd_idx (rd_idx),
    .rd_data(s_axi_rdata)
  );

endmodule

// File: tb/tb_axi_c2c_mem_responder.sv
// Scoreboard bench for axi_c2c_mem_responder; range-check cases follow
// AXI_C2C_RESP_RANGE_CHECK_EN.
module tb_axi_c2c_mem_responder;

  localparam int          ID_W   = 6;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  FIXED  = 2'b00;
  localparam logic [1:0]  INCR   = 2'b01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = INCR, arburst = INCR, bresp, rresp;
  logic [3:0]  wuser = '0, wstrb = '0;
  logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, rlast;

  axi_c2c_mem_responder #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .s_aclk(clk), .s_aresetn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wuser(wuser), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct packed {
    logic [31:0]     data;
    logic            last;
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } r_exp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  int checks = 0;
  int fails  = 0;

  r_exp_t      r_sb[$];
  r_exp_t      r_obs[$];
  b_exp_t      b_sb[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] model [int];

  function automatic r_exp_t mk_r(input logic [31:0] d, input logic l, input logic [1:0] r,
                                  input logic [ID_W-1:0] i);
    r_exp_t e;
    e.data = d; e.last = l; e.resp = r; e.id = i;
    return e;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & (DEPTH - 1);
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_C2C_RESP_RANGE_CHECK_EN
    return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'(4 * DEPTH)));
`else
    return 1'b1;
`endif
  endfunction

  task automatic timeout(input string what);
    checks++;
    fails++;
    $display("FAIL timeout_%s handshake never completed, required within 200 cycles", what);
  endtask

  // Expected read beats come from the bench's own memory model.
  task automatic push_read_exp(input logic [ID_W-1:0] id, input logic [31:0] addr,
                               input int len, input logic [1:0] burst);
    logic [31:0] a;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      if (in_range(a)) r_sb.push_back(mk_r(model[widx(a)], i == len, OKAY, id));
      else             r_sb.push_back(mk_r(32'h0, i == len, SLVERR, id));
      if (burst != FIXED) a = a + 32'd4;
    end
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [15:0] wlast_mask,
                          output logic [1:0] br, output logic [ID_W-1:0] bi);
    int n, k;
    logic [31:0] a;
    a = addr;
    br = 2'bxx;
    bi = 'x;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("aw");
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = wlast_mask[i]; wuser = 4'(i);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("w");
      if (in_range(a)) begin
        k = widx(a);
        if (!model.exists(k)) model[k] = 32'h0;
        for (int b = 0; b < 4; b++)
          if (wq_strb[i][b]) model[k][8*b +: 8] = wq_data[i][8*b +: 8];
      end
      @(negedge clk);
      if (burst != FIXED) a = a + 32'd4;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("b");
    br = bresp;
    bi = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // mode 0: rready always high; mode 1: rready pattern 1,0,0 repeating.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int mode,
                         output logic first_valid, output int hold_viol);
    int n, k, guard;
    logic have_prev;
    r_exp_t prev;
    r_obs.delete();
    hold_viol = 0;
    have_prev = 1'b0;
    prev = '0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("ar");
    @(negedge clk);
    arvalid = 1'b0;
    first_valid = rvalid;
    k = 0;
    guard = 0;
    while (r_obs.size() < int'(len) + 1 && guard < 2000) begin
      rready = (mode == 0) || (k % 3 == 0);
      if (rvalid) begin
        if (have_prev && (mk_r(rdata, rlast, rresp, rid) !== prev)) hold_viol++;
        if (rready) begin
          r_obs.push_back(mk_r(rdata, rlast, rresp, rid));
          have_prev = 1'b0;
        end else begin
          prev = mk_r(rdata, rlast, rresp, rid);
          have_prev = 1'b1;
        end
      end
      @(negedge clk);
      k++;
      guard++;
    end
    if (guard >= 2000) timeout("r");
    rready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_ctrl got aw/ar/w/b/r/last=%b required 110000",
               {awready, arready, wready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bresp, rresp, bid, rid, rdata} !== '0) begin
      fails++;
      $display("FAIL reset_data got bresp=%h rresp=%h bid=%h rid=%h rdata=%h required all 0",
               bresp, rresp, bid, rid, rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incr;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; b_exp_t be; r_exp_t e, o;
    wq_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    b_sb.push_back('{id: 6'h05, resp: OKAY});
    do_write(6'h05, 32'h10, 8'd3, INCR, 16'h0008, br, bi);
    be = b_sb.pop_front();
    checks++;
    if ({bi, br} !== {be.id, be.resp}) begin
      fails++;
      $display("FAIL incr_b got id=%h resp=%h required id=%h resp=%h", bi, br, be.id, be.resp);
    end
    for (int i = 0; i < 4; i++) r_sb.push_back(mk_r(32'hA0 + 32'(i), i == 3, OKAY, 6'h11));
    do_read(6'h11, 32'h10, 8'd3, INCR, 0, fv, hv);
    checks++;
    if (fv !== 1'b1) begin
      fails++;
      $display("FAIL incr_latency rvalid one cycle after AR got %b required 1", fv);
    end
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL incr_rbeat got d=%h l=%b r=%h id=%h required d=%h l=%b r=%h id=%h",
                 o.data, o.last, o.resp, o.id, e.data, e.last, e.resp, e.id);
      end
    end
    checks++;
    if (rvalid !== 1'b0) begin
      fails++;
      $display("FAIL incr_rvalid_after_last got %b required 0", rvalid);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
    wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
    do_write(6'h01, 32'h40, 8'd0, INCR, 16'h0001, br, bi);
    wq_data = '{32'h00000055}; wq_strb = '{4'h1};
    b_sb.push_back('{id: 6'h02, resp: OKAY});
    do_write(6'h02, 32'h40, 8'd0, INCR, 16'h0001, br, bi);
    checks++;
    if ({bi, br} !== b_sb.pop_front()) begin
      fails++;
      $display("FAIL strobe_b got id=%h resp=%h required id=02 resp=0", bi, br);
    end
    r_sb.push_back(mk_r(32'hDEADBE55, 1'b1, OKAY, 6'h03));
    do_read(6'h03, 32'h40, 8'd0, INCR, 0, fv, hv);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL strobe_rbeat got d=%h l=%b r=%h required d=%h l=%b r=%h",
               o.data, o.last, o.resp, e.data, e.last, e.resp);
    end
  endtask

  task automatic test_fixed;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
    wq_data = '{32'h12345678}; wq_strb = '{4'hF};
    do_write(6'h04, 32'h84, 8'd0, INCR, 16'h0001, br, bi);
    wq_data = '{32'h1, 32'h2, 32'h3}; wq_strb = '{4'hF, 4'hF, 4'hF};
    b_sb.push_back('{id: 6'h06, resp: OKAY});
    do_write(6'h06, 32'h80, 8'd2, FIXED, 16'h0004, br, bi);
    checks++;
    if ({bi, br} !== b_sb.pop_front()) begin
      fails++;
      $display("FAIL fixed_b got id=%h resp=%h required id=06 resp=0", bi, br);
    end
    r_sb.push_back(mk_r(32'h3, 1'b1, OKAY, 6'h07));
    r_sb.push_back(mk_r(32'h12345678, 1'b1, OKAY, 6'h07));
    r_sb.push_back(mk_r(32'h3, 1'b0, OKAY, 6'h08));
    r_sb.push_back(mk_r(32'h3, 1'b1, OKAY, 6'h08));
    do_read(6'h07, 32'h80, 8'd0, INCR, 0, fv, hv);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL fixed_rd80 got d=%h required d=%h", o.data, e.data);
    end
    do_read(6'h07, 32'h84, 8'd0, INCR, 0, fv, hv);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL fixed_rd84_untouched got d=%h required d=%h", o.data, e.data);
    end
    do_read(6'h08, 32'h80, 8'd1, FIXED, 0, fv, hv);
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL fixed_rburst got d=%h l=%b required d=%h l=%b", o.data, o.last, e.data, e.last);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
    wq_data.delete(); wq_strb.delete();
    for (int i = 0; i < 8; i++) begin
      wq_data.push_back($urandom);
      wq_strb.push_back(4'hF);
    end
    do_write(6'h09, 32'h200, 8'd7, INCR, 16'h0080, br, bi);
    checks++;
    if (br !== OKAY) begin
      fails++;
      $display("FAIL bp_b got resp=%h required 0", br);
    end
    push_read_exp(6'h2A, 32'h200, 7, INCR);
    do_read(6'h2A, 32'h200, 8'd7, INCR, 1, fv, hv);
    checks++;
    if (hv !== 0) begin
      fails++;
      $display("FAIL bp_hold got %0d changes during stalls required 0", hv);
    end
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL bp_rbeat got d=%h l=%b r=%h id=%h required d=%h l=%b r=%h id=%h",
                 o.data, o.last, o.resp, o.id, e.data, e.last, e.resp, e.id);
      end
    end
    checks++;
    if (rvalid !== 1'b0) begin
      fails++;
      $display("FAIL bp_extra_beat rvalid got %b required 0", rvalid);
    end
  endtask

  task automatic test_wlast_err;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
    wq_data = '{32'hB0, 32'hB1, 32'hB2, 32'hB3}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    b_sb.push_back('{id: 6'h0A, resp: SLVERR});
    do_write(6'h0A, 32'h300, 8'd3, INCR, 16'h0002, br, bi);
    checks++;
    if ({bi, br} !== b_sb.pop_front()) begin
      fails++;
      $display("FAIL wlast_err_b got id=%h resp=%h required id=0a resp=2", bi, br);
    end
    for (int i = 0; i < 4; i++) r_sb.push_back(mk_r(32'hB0 + 32'(i), i == 3, OKAY, 6'h0B));
    do_read(6'h0B, 32'h300, 8'd3, INCR, 0, fv, hv);
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wlast_err_beats got d=%h l=%b required d=%h l=%b", o.data, o.last, e.data, e.last);
      end
    end
    wq_data = '{32'hC0, 32'hC1}; wq_strb = '{4'hF, 4'hF};
    b_sb.push_back('{id: 6'h0C, resp: OKAY});
    do_write(6'h0C, 32'h310, 8'd1, INCR, 16'h0002, br, bi);
    checks++;
    if ({bi, br} !== b_sb.pop_front()) begin
      fails++;
      $display("FAIL wlast_err_recover_b got id=%h resp=%h required id=0c resp=0", bi, br);
    end
  endtask

  task automatic test_parallel;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
    wq_data = '{32'hD0, 32'hD1, 32'hD2, 32'hD3}; wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
    push_read_exp(6'h15, 32'h200, 7, INCR);
    b_sb.push_back('{id: 6'h14, resp: OKAY});
    fork
      do_write(6'h14, 32'h400, 8'd3, INCR, 16'h0008, br, bi);
      do_read(6'h15, 32'h200, 8'd7, INCR, 0, fv, hv);
    join
    checks++;
    if ({bi, br} !== b_sb.pop_front()) begin
      fails++;
      $display("FAIL par_b got id=%h resp=%h required id=14 resp=0", bi, br);
    end
    push_read_exp(6'h16, 32'h400, 3, INCR);
    while (r_obs.size() > 0 || r_sb.size() > 4) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL par_rbeat got d=%h id=%h required d=%h id=%h", o.data, o.id, e.data, e.id);
      end
      if (r_sb.size() <= 4) r_obs.delete();
    end
    do_read(6'h16, 32'h400, 8'd3, INCR, 0, fv, hv);
    while (r_sb.size() > 0) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL par_wcheck got d=%h required d=%h", o.data, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int n; logic fv; int hv; r_exp_t e, o;
    @(negedge clk);
    arid = 6'h33; araddr = 32'h200; arlen = 8'd7; arburst = INCR; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("rst_ar");
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!rvalid || rdata !== model[widx(32'h208)]) begin
      fails++;
      $display("FAIL rst_beat2 got v=%b d=%h required v=1 d=%h", rvalid, rdata, model[widx(32'h208)]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, arready, awready} !== 4'b0011 || rid !== '0) begin
      fails++;
      $display("FAIL rst_abort got rvalid=%b rlast=%b arready=%b awready=%b rid=%h required 0 0 1 1 00",
               rvalid, rlast, arready, awready, rid);
    end
    @(negedge clk);
    rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_r_after got rvalid=%b required 0", rvalid);
    end
    push_read_exp(6'h34, 32'h200, 0, INCR);
    do_read(6'h34, 32'h200, 8'd0, INCR, 0, fv, hv);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL rst_mem_kept got d=%h required d=%h", o.data, e.data);
    end
  endtask

  task automatic test_range;
    logic [1:0] br; logic [ID_W-1:0] bi; logic fv; int hv; r_exp_t e, o;
`ifdef AXI_C2C_RESP_RANGE_CHECK_EN
    wq_data = '{32'h0BADF00D}; wq_strb = '{4'hF};
    do_write(6'h20, BASE, 8'd0, INCR, 16'h0001, br, bi);
    wq_data = '{32'hE0, 32'hE1}; wq_strb = '{4'hF, 4'hF};
    do_write(6'h21, BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, INCR, 16'h0002, br, bi);
    checks++;
    if (br !== SLVERR) begin
      fails++;
      $display("FAIL range_wr_b got resp=%h required 2", br);
    end
    r_sb.push_back(mk_r(32'h0, 1'b1, SLVERR, 6'h22));
    do_read(6'h22, BASE + 32'(4 * DEPTH), 8'd0, INCR, 0, fv, hv);
    push_read_exp(6'h23, BASE + 32'(4 * DEPTH) - 32'd4, 1, INCR);
    push_read_exp(6'h24, BASE, 0, INCR);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL range_rd_oor got d=%h r=%h required d=%h r=%h", o.data, o.resp, e.data, e.resp);
    end
    do_read(6'h23, BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, INCR, 0, fv, hv);
    for (int i = 0; i < 2; i++) begin
      e = r_sb.pop_front(); o = '0;
      if (r_obs.size() > 0) o = r_obs.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL range_rd_straddle got d=%h r=%h l=%b required d=%h r=%h l=%b",
                 o.data, o.resp, o.last, e.data, e.resp, e.last);
      end
    end
    do_read(6'h24, BASE, 8'd0, INCR, 0, fv, hv);
`else
    wq_data = '{32'h77}; wq_strb = '{4'hF};
    do_write(6'h20, BASE + 32'(4 * DEPTH), 8'd0, INCR, 16'h0001, br, bi);
    checks++;
    if (br !== OKAY) begin
      fails++;
      $display("FAIL alias_wr_b got resp=%h required 0", br);
    end
    r_sb.push_back(mk_r(32'hA0, 1'b1, OKAY, 6'h25));
    do_read(6'h25, BASE + 32'(4 * DEPTH) + 32'h10, 8'd0, INCR, 0, fv, hv);
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL alias_rd got d=%h r=%h required d=%h r=%h", o.data, o.resp, e.data, e.resp);
    end
    r_sb.push_back(mk_r(32'h77, 1'b1, OKAY, 6'h24));
    do_read(6'h24, BASE, 8'd0, INCR, 0, fv, hv);
`endif
    e = r_sb.pop_front(); o = '0;
    if (r_obs.size() > 0) o = r_obs.pop_front();
    checks++;
    if (o !== e) begin
      fails++;
      $display("FAIL range_word0 got d=%h r=%h required d=%h r=%h", o.data, o.resp, e.data, e.resp);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_fixed();
    test_backpressure();
    test_wlast_err();
    test_parallel();
    test_reset_mid_read();
    test_range();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded 500000 time units, required completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
